psum_ofifo: RTL
===============

# psum_ofifo

Output collection buffer on the south edge of the MAC array. It captures the skewed, per-column `valid`/`out_s` partial-sum stream: column c's results arrive c cycles after column 0's. It re-aligns them into full-width rows that downstream logic (SFU / psum write-back to SRAM) pops one row at a time. It uses one independent FIFO per column, a common read, and flags for readiness, fullness and overflow.

## Interface
- `psum_bw`, 16, width of one column's partial sum
- `col`, 8, number of array columns / column FIFOs
- `depth`, 64, entries per column FIFO; power of two, ≥ 2
- `clk`  input  1  single clock; all state updates on posedge
- `reset`  input  1  asynchronous, active-high; clears all state immediately
- `in`  input  psum_bw*col  psum row from array `out_s`; column c at [psum_bw*(c+1)-1 : psum_bw*c]
- `wr`  input  col  per-column write strobe, driven by array `valid`
- `rd`  input  1  pop one full row
- `out`  output  psum_bw*col  registered popped row, same column packing as `in`
- `o_valid`  output  1  every column FIFO holds ≥ 1 entry
- `o_full`  output  1  any column FIFO holds `depth` entries
- `o_ready`  output  1  no column FIFO is full (= !o_full)
- `o_overflow`  output  1  sticky: a write was dropped

## Operation
- Per column c: write pointer, read pointer, occupancy count 0..depth (width $clog2(depth)+1). Storage is `depth` × `psum_bw`.
- Read acceptance: `rd_acc = rd && o_valid`. All columns pop together; there are no per-column reads.
- Write acceptance, column c: `wr_acc[c] = wr[c] && (count[c] < depth || rd_acc)`. A full column still accepts a write in the same cycle as an accepted read; its count stays at depth.
- Dropped write (`wr[c]` && !`wr_acc[c]`): data discarded, pointers unchanged, `o_overflow` set to 1 and held until reset.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Pointers wrap modulo depth (natural binary wrap).
- `rd` while `o_valid`=0: ignored; `out`, pointers and counts unchanged. No bypass: a write to an empty column plus `rd` in the same cycle does not pop.
- `out` updates only on `rd_acc`, loading each column's head entry. Otherwise it holds its value.
- `o_valid` = AND over columns of (count ≠ 0); `o_full` = OR over columns of (count == depth). Both are combinational from registered counts, so glitch-free relative to `clk`.
- Columns are fully independent in fill level. Skew between columns is absorbed by storage; no alignment logic beyond the common read.

## Timing
- Reset values: `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0; all pointers and counts 0. Memory contents are don't-care.
- Reset mid-operation: all buffered rows are discarded. Flags return to reset values asynchronously.
- Write at edge k → that column's count is incremented after edge k.
- With array skew, row 0 column c is written at edge k+c. `o_valid` rises after edge k+col-1.
- Read latency is 1: `rd_acc` at edge k → popped row on `out` after edge k. `o_valid` falls after edge k if that emptied any column.
- Back-to-back reads: one row per cycle while `o_valid` stays 1.
- Full: `o_full` rises after the edge that writes entry `depth` into any column. It falls after the first `rd_acc` edge without a simultaneous write to that column.

## Test plan
- Reset/idle: assert `reset` mid-cycle → all outputs at reset values immediately; `rd`=1 for 5 cycles with empty FIFOs → `out`=0, `o_valid`=0.
- Skewed fill: column c gets `wr[c]` at cycles c..c+3 with psum value 16·r+c for row r → `o_valid` rises after cycle 7. Four reads then give `out` column c = 16·r+c for r = 0..3, and `o_valid`=0 after the 4th.
- Full and overflow: 64 writes to all columns → `o_full`=1, `o_ready`=0. A 65th write to column 3 only → dropped, `o_overflow`=1. Rows 0..63 read back intact, and `o_overflow` stays 1.
- Full with simultaneous read+write: fill to 64, then `rd`=1 and `wr`=all ones with value 0xBEEF in the same cycle → no overflow, `o_full` stays 1. The 64th subsequent read returns 0xBEEF in every column.
- Wrap-around: stream 200 rows with interleaved reads, keeping occupancy 1..10 → every row is returned in order, no overflow, and pointers wrap past 63 at least 3 times.
- Reset mid-operation: 20 rows buffered, pulse `reset` → `o_valid`=0. Then 1 new row written and read → `out` equals the new row, not stale data.

Source files
------------

// File: rtl/psum_ofifo.sv
// South-edge output buffer: one FIFO per array column absorbs the column skew,
// and a common read pops a complete, re-aligned psum row.
module psum_ofifo #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [psum_bw-1:0] mem  [col][depth];
  logic [AW-1:0]      wptr [col];
  logic [AW-1:0]      rptr [col];
  logic [CW-1:0]      cnt  [col];

  logic [col-1:0] not_empty;
  logic [col-1:0] is_full;
  logic [col-1:0] wr_acc;
  logic           rd_acc;

  always_comb begin
    not_empty = '0;
    is_full   = '0;
    for (int c = 0; c < col; c++) begin
      not_empty[c] = (cnt[c] != '0);
      is_full[c]   = (cnt[c] == FULL_CNT);
    end
  end

  assign o_valid = &not_empty;
  assign o_full  = |is_full;
  assign o_ready = !o_full;
  assign rd_acc  = rd && o_valid;
  // A full column still takes a write when the common read frees a slot.
  assign wr_acc  = wr & (~is_full | {col{rd_acc}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
      o_overflow <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        if (wr_acc[c]) wptr[c] <= wptr[c] + AW'(1);
        if (rd_acc)    rptr[c] <= rptr[c] + AW'(1);
        case ({wr_acc[c], rd_acc})
          2'b10:   cnt[c] <= cnt[c] + CW'(1);
          2'b01:   cnt[c] <= cnt[c] - CW'(1);
          default: ;
        endcase
      end
      if (|(wr & ~wr_acc)) o_overflow <= 1'b1;
    end
  end

  // Storage array carries no reset; contents are only observed through counts.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (wr_acc[c]) mem[c][wptr[c]] <= in[c*psum_bw +: psum_bw];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if (rd_acc) begin
      for (int c = 0; c < col; c++) begin
        out[c*psum_bw +: psum_bw] <= mem[c][rptr[c]];
      end
    end
  end

endmodule
